// File: rtl/mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_pkg : shared types and constants for the sequential multiplier |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mul_pkg;

  localparam int C_WIDTH_DEF = 16;

  // Iteration counter width, kept at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int C_CNT_W_DEF = cnt_width(C_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/acc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | acc_reg : write-enabled accumulator register, sync active-low rst  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module acc_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wen,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_wen) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_seq_ctrl : shift-add sequential multiplier, one bit per cycle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int C_CW = cnt_width(WIDTH);
  localparam int C_AW = 2 * WIDTH + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WIDTH-1:0]  r_mcand;
  logic [C_CW-1:0]   r_count;
  logic [C_CW-1:0]   w_count_nxt;
  logic [C_AW-1:0]   w_acc;
  logic [C_AW-1:0]   w_acc_d;
  logic              w_acc_wen;
  logic              w_accept;
  logic              w_last;
  logic [WIDTH:0]    w_sum;

  acc_reg #(
    .W (C_AW)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_wen (w_acc_wen),
    .i_d   (w_acc_d),
    .o_q   (w_acc)
  );

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_count == C_CW'(WIDTH - 1));
  assign w_sum    = {1'b0, w_acc[2*WIDTH-1:WIDTH]}
                  + (w_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_mcand <= a;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_d     = w_acc;
    w_acc_wen   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_acc_d     = {{(WIDTH+1){1'b0}}, b};
          w_acc_wen   = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        // Multiplier bits retire from the LSB while partial sums enter at the top.
        w_acc_d   = {1'b0, w_sum, w_acc[WIDTH-1:1]};
        w_acc_wen = 1'b1;
        if (w_last) begin
          w_count_nxt = '0;
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + C_CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = w_acc[2*WIDTH-1:0];

  // The carry guard bit must have drained by the time the result is presented.
  a_acc_msb_clear : assert property (@(posedge clk) disable iff (!rst)
    (r_state == DONE) |-> !w_acc[C_AW-1]);

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; product register width is 2*WIDTH+1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request pulse; samples a/b when accepted.
REQ-005 a  input  WIDTH  multiplicand (unsigned).
REQ-006 b  input  WIDTH  multiplier (unsigned).
REQ-007 busy  output  1  high while iterating.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  2*WIDTH  result, acc[2*WIDTH-1:0].

Function
REQ-010 FSM states SHALL be exactly IDLE, RUN and DONE.
REQ-011 Start SHALL be accepted only in IDLE or DONE.
- On acceptance: a latched into mcand; acc <= {(WIDTH+1)'b0, b}; count <= 0; next state RUN.
REQ-012 Start in RUN SHALL be ignored with no effect on acc, count or operands.
REQ-013 Each RUN cycle SHALL perform one shift-add step.
- sum[WIDTH:0] = acc[2W-1:W] + (acc[0] ? mcand : 0)
- acc <= {1'b0, sum, acc[W-1:1]}
REQ-014 count SHALL increment each RUN cycle and is log2(WIDTH) bits wide.
- When count == WIDTH-1: the step completes, count wraps to 0 and the next state is DONE.
REQ-015 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-016 DONE SHALL last one cycle, then go to IDLE unless start is accepted, in which case it goes to RUN.
REQ-017 Latency: start accepted at edge N SHALL give done high in the cycle after edge N+WIDTH (17 cycles for WIDTH=16).
REQ-018 product SHALL equal a*b (mod 2^(2W)) while done is high.
- product SHALL hold that value until the next accepted start.
REQ-019 acc[2W] SHALL be 0 whenever the FSM is in DONE.
REQ-020 The accumulator register SHALL be written only on accept or in RUN; it holds otherwise.

Reset
REQ-021 rst low at a rising edge SHALL force the following, regardless of state:
- state IDLE
- acc 0, mcand 0, count 0
- busy 0, done 0, product 0
REQ-022 Reset during RUN SHALL abort the operation; no done pulse for that operation SHALL ever occur.
REQ-023 rst takes priority over start in the same cycle.

Structure
REQ-024 Shared package mul_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE)
- the default WIDTH constant
- the derived count width.
REQ-025 The accumulator SHALL be one sub-module, acc_reg.
- 2*WIDTH+1 bits, write enable, synchronous active-low reset.
- The controller drives its d/wen; all sequencing stays in mul_seq_ctrl.
REQ-026 No combinational path from start, a or b to busy, done or product.

Verification
REQ-027 a=3, b=5, start one cycle -> busy for 16 cycles, done at cycle 17, product=0x0000000F.
REQ-028 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 with done; acc[32]=0.
REQ-029 a=0x1234, b=0 -> product=0x00000000 at cycle 17.
REQ-030 Start with a=2, b=2; at cycle 5 start with a=7, b=7 -> second start ignored; product=0x00000004.
REQ-031 Start with a=9, b=9; rst low at cycle 8 -> cycle after: busy=0, done=0, product=0; done never asserts.
REQ-032 Start held high in the DONE cycle with a=6, b=7 (first op a=2, b=3) -> product 6 with done, then busy the next cycle, then product 42 with done 17 cycles later.
